// File: rtl/alu_types.sv
// rtl/alu_types.sv - ALU control encodings and shared constants for the ID/EX stage
package alu_types;

  typedef logic [3:0] alu_control_t;

  localparam alu_control_t ALU_ADD  = 4'b1000;
  localparam alu_control_t ALU_SUB  = 4'b1100;
  localparam alu_control_t ALU_SLT  = 4'b1101;
  localparam alu_control_t ALU_SLTU = 4'b1111;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side and execute-side handshake bundle of the ID/EX stage
interface id_ex_stage_if #(
  parameter int N  = 32,
  parameter int RA = 5
);
  import alu_types::*;

  logic          in_valid;
  logic          in_ready;
  logic [RA-1:0] in_rs1_addr;
  logic [RA-1:0] in_rs2_addr;
  logic [N-1:0]  in_rs1_data;
  logic [N-1:0]  in_rs2_data;
  logic [RA-1:0] in_rd_addr;
  logic          in_reg_write;
  logic [N-1:0]  in_imm;
  logic          in_b_sel_imm;
  logic          in_a_sel_pc;
  logic [N-1:0]  in_pc;
  alu_control_t  in_alu_control;

  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  alu_control_t  alu_control;
  logic [RA-1:0] out_rd_addr;
  logic          out_reg_write;

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_rd_addr, in_reg_write, in_imm, in_b_sel_imm, in_a_sel_pc,
           in_pc, in_alu_control, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, out_rd_addr,
           out_reg_write
  );

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_rd_addr, in_reg_write, in_imm, in_b_sel_imm, in_a_sel_pc,
           in_pc, in_alu_control, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, out_rd_addr,
           out_reg_write
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - resolves one source operand from RF, EX/MEM or MEM/WB
module operand_fwd_mux
  import alu_types::*;
#(
  parameter int N  = 32,
  parameter int RA = 5
) (
  input  logic [RA-1:0] addr,
  input  logic [N-1:0]  rf_data,
  input  logic          ex_valid,
  input  logic [RA-1:0] ex_rd,
  input  logic [N-1:0]  ex_data,
  input  logic          wb_valid,
  input  logic [RA-1:0] wb_rd,
  input  logic [N-1:0]  wb_data,
  output logic [N-1:0]  data
);

  always_comb begin
    data = rf_data;
    // x0 reads as zero even if a producer claims to write it
    if (addr == RA'(REG_ZERO)) begin
      data = '0;
    end else if (ex_valid && (ex_rd == addr)) begin
      data = ex_data;
    end else if (wb_valid && (wb_rd == addr)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute register driving ALU operands and control
module id_ex_stage
  import alu_types::*;
#(
  parameter int N    = 32,
  parameter int RA   = 5,
  parameter int SC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  id_ex_stage_if.slave    bus,
  input  logic            ex_fwd_valid,
  input  logic [RA-1:0]   ex_fwd_rd,
  input  logic [N-1:0]    ex_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [RA-1:0]   wb_fwd_rd,
  input  logic [N-1:0]    wb_fwd_data,
  output logic [SC_W-1:0] stall_count
);

  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  alu_control_t    alu_control_q, alu_control_d;
  logic [RA-1:0]   rd_addr_q, rd_addr_d;
  logic            reg_write_q, reg_write_d;
  logic [RA-1:0]   rs1_q, rs1_d;
  logic [RA-1:0]   rs2_q, rs2_d;
  logic            a_sel_pc_q, a_sel_pc_d;
  logic            b_sel_imm_q, b_sel_imm_d;
  logic [SC_W-1:0] stall_q, stall_d;

  logic [N-1:0] rs1_resolved;
  logic [N-1:0] rs2_resolved;
  logic         capture;
  logic         hold;

  operand_fwd_mux #(.N(N), .RA(RA)) u_rs1_mux (
    .addr    (bus.in_rs1_addr),
    .rf_data (bus.in_rs1_data),
    .ex_valid(ex_fwd_valid),
    .ex_rd   (ex_fwd_rd),
    .ex_data (ex_fwd_data),
    .wb_valid(wb_fwd_valid),
    .wb_rd   (wb_fwd_rd),
    .wb_data (wb_fwd_data),
    .data    (rs1_resolved)
  );

  operand_fwd_mux #(.N(N), .RA(RA)) u_rs2_mux (
    .addr    (bus.in_rs2_addr),
    .rf_data (bus.in_rs2_data),
    .ex_valid(ex_fwd_valid),
    .ex_rd   (ex_fwd_rd),
    .ex_data (ex_fwd_data),
    .wb_valid(wb_fwd_valid),
    .wb_rd   (wb_fwd_rd),
    .wb_data (wb_fwd_data),
    .data    (rs2_resolved)
  );

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign capture      = bus.in_valid & bus.in_ready & ~flush;
  assign hold         = out_valid_q & ~bus.out_ready & ~flush;

  always_comb begin
    out_valid_d   = out_valid_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_control_d = alu_control_q;
    rd_addr_d     = rd_addr_q;
    reg_write_d   = reg_write_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    a_sel_pc_d    = a_sel_pc_q;
    b_sel_imm_d   = b_sel_imm_q;

    if (flush) begin
      out_valid_d = 1'b0;
      reg_write_d = 1'b0;
    end else if (capture) begin
      out_valid_d   = 1'b1;
      alu_a_d       = bus.in_a_sel_pc  ? bus.in_pc  : rs1_resolved;
      alu_b_d       = bus.in_b_sel_imm ? bus.in_imm : rs2_resolved;
      alu_control_d = bus.in_alu_control;
      rd_addr_d     = bus.in_rd_addr;
      reg_write_d   = bus.in_reg_write;
      rs1_d         = bus.in_rs1_addr;
      rs2_d         = bus.in_rs2_addr;
      a_sel_pc_d    = bus.in_a_sel_pc;
      b_sel_imm_d   = bus.in_b_sel_imm;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else if (hold) begin
      // A held entry may have captured stale RF data; WB writes landing now patch it
      if (wb_fwd_valid && !a_sel_pc_q && (rs1_q != RA'(REG_ZERO)) && (wb_fwd_rd == rs1_q))
        alu_a_d = wb_fwd_data;
      if (wb_fwd_valid && !b_sel_imm_q && (rs2_q != RA'(REG_ZERO)) && (wb_fwd_rd == rs2_q))
        alu_b_d = wb_fwd_data;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !bus.out_ready && (stall_q != {SC_W{1'b1}}))
      stall_d = stall_q + SC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= 4'b0000;
      rd_addr_q     <= '0;
      reg_write_q   <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      a_sel_pc_q    <= 1'b0;
      b_sel_imm_q   <= 1'b0;
      stall_q       <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      rd_addr_q     <= rd_addr_d;
      reg_write_q   <= reg_write_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      a_sel_pc_q    <= a_sel_pc_d;
      b_sel_imm_q   <= b_sel_imm_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_control   = alu_control_q;
  assign bus.out_rd_addr   = rd_addr_q;
  assign bus.out_reg_write = reg_write_q;
  assign stall_count       = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed-vector bench for id_ex_stage
module tb_id_ex_stage;
  import alu_types::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_fwd_valid;
  logic [4:0]  ex_fwd_rd;
  logic [31:0] ex_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic [15:0] stall_count;

  int n_vec;
  int n_err;

  id_ex_stage_if #(.N(32), .RA(5)) bus ();

  id_ex_stage #(.N(32), .RA(5), .SC_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .ex_fwd_valid(ex_fwd_valid),
    .ex_fwd_rd   (ex_fwd_rd),
    .ex_fwd_data (ex_fwd_data),
    .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_rd   (wb_fwd_rd),
    .wb_fwd_data (wb_fwd_data),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    flush = 1'b0;
    ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    bus.in_valid = 1'b0;
    bus.in_rs1_addr = '0; bus.in_rs2_addr = '0;
    bus.in_rs1_data = '0; bus.in_rs2_data = '0;
    bus.in_rd_addr = '0; bus.in_reg_write = 1'b0;
    bus.in_imm = '0; bus.in_b_sel_imm = 1'b0; bus.in_a_sel_pc = 1'b0;
    bus.in_pc = '0; bus.in_alu_control = ALU_ADD;
    bus.out_ready = 1'b1;

    #2;
    check_vec("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_vec("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check_vec("rst_stall", 64'(stall_count), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Forwarding priority: EX over WB over RF
    bus.in_valid = 1'b1;
    bus.in_rs1_addr = 5'd5; bus.in_rs1_data = 32'hDEADBEEF;
    bus.in_b_sel_imm = 1'b1; bus.in_imm = 32'h0;
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_data = 32'hAAAA0000;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h11111111;
    tick();
    check_vec("fwd_valid", 64'(bus.out_valid), 64'd1);
    check_vec("fwd_ex", 64'(bus.alu_a), 64'hAAAA0000);
    ex_fwd_valid = 1'b0;
    tick();
    check_vec("fwd_wb", 64'(bus.alu_a), 64'h11111111);
    bus.in_rs1_addr = 5'd0;
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
    tick();
    check_vec("fwd_x0", 64'(bus.alu_a), 64'd0);
    ex_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;

    // Immediate and PC operand select
    bus.in_a_sel_pc = 1'b1; bus.in_pc = 32'h100;
    bus.in_b_sel_imm = 1'b1; bus.in_imm = 32'hFFFFFFFC;
    bus.in_alu_control = ALU_ADD; bus.in_rd_addr = 5'd3; bus.in_reg_write = 1'b1;
    tick();
    check_vec("sel_a_pc", 64'(bus.alu_a), 64'h100);
    check_vec("sel_b_imm", 64'(bus.alu_b), 64'hFFFFFFFC);
    check_vec("sel_ctrl", 64'(bus.alu_control), 64'h8);
    check_vec("sel_rd", 64'(bus.out_rd_addr), 64'd3);
    check_vec("sel_regwr", 64'(bus.out_reg_write), 64'd1);

    // Drain, then backpressure with WB refresh of held rs2
    bus.in_valid = 1'b0;
    tick();
    check_vec("drain_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_a_sel_pc = 1'b0; bus.in_rs1_addr = 5'd1; bus.in_rs1_data = 32'h10;
    bus.in_b_sel_imm = 1'b0; bus.in_rs2_addr = 5'd7; bus.in_rs2_data = 32'h99;
    bus.in_alu_control = ALU_SUB;
    tick();
    check_vec("bp_cap_b", 64'(bus.alu_b), 64'h99);
    bus.out_ready = 1'b0;
    bus.in_rs2_data = 32'h55; bus.in_rs1_data = 32'h77; bus.in_alu_control = ALU_SLT;
    #1;
    check_vec("bp_in_ready", 64'(bus.in_ready), 64'd0);
    tick(); tick(); tick();
    check_vec("bp_stall3", 64'(stall_count), 64'd3);
    check_vec("bp_hold_a", 64'(bus.alu_a), 64'h10);
    check_vec("bp_hold_b", 64'(bus.alu_b), 64'h99);
    check_vec("bp_hold_ctrl", 64'(bus.alu_control), 64'(ALU_SUB));
    check_vec("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h42;
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 32'hEE;
    tick();
    check_vec("bp_refresh_b", 64'(bus.alu_b), 64'h42);
    check_vec("bp_refresh_a", 64'(bus.alu_a), 64'h10);
    check_vec("bp_stall4", 64'(stall_count), 64'd4);
    wb_fwd_valid = 1'b0; ex_fwd_valid = 1'b0;

    // Back-to-back: simultaneous drain and capture, no bubbles
    bus.out_ready = 1'b1;
    bus.in_a_sel_pc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alu_control_t c;
      c = i[0] ? ALU_SUB : ALU_SLTU;
      bus.in_pc = 32'h1000 + 32'(i) * 4;
      bus.in_alu_control = c;
      tick();
      check_vec($sformatf("b2b_valid%0d", i), 64'(bus.out_valid), 64'd1);
      check_vec($sformatf("b2b_a%0d", i), 64'(bus.alu_a), 64'(32'h1000 + 32'(i) * 4));
      check_vec($sformatf("b2b_ctrl%0d", i), 64'(bus.alu_control), 64'(c));
    end
    check_vec("b2b_stall", 64'(stall_count), 64'd4);

    // Flush beats a simultaneous capture
    bus.in_reg_write = 1'b1;
    flush = 1'b1;
    #1;
    check_vec("fl_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check_vec("fl_valid", 64'(bus.out_valid), 64'd0);
    check_vec("fl_regwr", 64'(bus.out_reg_write), 64'd0);
    flush = 1'b0;
    bus.in_pc = 32'h200;
    tick();
    check_vec("fl_after_valid", 64'(bus.out_valid), 64'd1);
    check_vec("fl_after_a", 64'(bus.alu_a), 64'h200);
    check_vec("fl_after_regwr", 64'(bus.out_reg_write), 64'd1);

    // Reset while holding clears state without a clock edge
    bus.out_ready = 1'b0;
    tick(); tick();
    check_vec("mh_stall", 64'(stall_count), 64'd6);
    rst = 1'b1;
    #1;
    check_vec("mh_valid", 64'(bus.out_valid), 64'd0);
    check_vec("mh_a", 64'(bus.alu_a), 64'd0);
    check_vec("mh_b", 64'(bus.alu_b), 64'd0);
    check_vec("mh_ctrl", 64'(bus.alu_control), 64'd0);
    check_vec("mh_stall0", 64'(stall_count), 64'd0);
    check_vec("mh_regwr", 64'(bus.out_reg_write), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU and drives its a, b and control inputs from registers.
- Resolves operands at capture time: register-file data, EX/MEM or MEM/WB forwarded data, immediate, or PC.
- Single-entry buffer with valid/ready handshake, flush, and a saturating stall counter for performance debug.

Parameters:
- N, 32, datapath width
- RA, 5, register address width
- SC_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard held entry and any capture this cycle
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept
- in_rs1_addr, in_rs2_addr  in  RA  source register addresses
- in_rs1_data, in_rs2_data  in  N  register-file read data
- in_rd_addr  in  RA  destination register
- in_reg_write  in  1  instruction writes rd
- in_imm  in  N  sign-extended immediate
- in_b_sel_imm  in  1  B operand = immediate
- in_a_sel_pc  in  1  A operand = in_pc
- in_pc  in  N  instruction PC
- in_alu_control  in  alu_control_t  ALU operation
- ex_fwd_valid  in  1  EX/MEM result is writing a register
- ex_fwd_rd  in  RA  EX/MEM destination
- ex_fwd_data  in  N  EX/MEM result
- wb_fwd_valid  in  1  MEM/WB result is writing a register
- wb_fwd_rd  in  RA  MEM/WB destination
- wb_fwd_data  in  N  MEM/WB result
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  execute stage accepts
- alu_a, alu_b  out  N  registered ALU operands
- alu_control  out  alu_control_t  registered ALU operation
- out_rd_addr  out  RA  registered destination
- out_reg_write  out  1  registered write enable
- stall_count  out  SC_W  cycles with out_valid & ~out_ready, saturating

Behaviour:
- Reset (async, rst=1): out_valid=0, alu_a=0, alu_b=0, alu_control=4'b0000, out_rd_addr=0, out_reg_write=0, stall_count=0, and internal held rs addrs/select flags cleared.
- in_ready = ~out_valid | out_ready (combinational, no dependence on in_valid).
- Capture: if in_valid & in_ready & ~flush, register all outputs next edge and set out_valid=1. Latency is one cycle.
- Drain: if out_valid & out_ready and no capture, out_valid goes to 0 next edge. The remaining output registers hold their values.
- Flush: priority over capture and hold. Next edge out_valid=0 and out_reg_write=0. Data registers need not change.
- Operand resolution (per source, shared sub-module):
  - Address 0 never forwards; the result is 0 regardless of in_rsX_data.
  - Otherwise, if ex_fwd_valid and ex_fwd_rd matches, use ex_fwd_data. EX has priority over WB.
  - Otherwise, if wb_fwd_valid and wb_fwd_rd matches, use wb_fwd_data.
  - Otherwise, use in_rsX_data.
- Operand selection:
  - alu_a = in_a_sel_pc ? in_pc : resolved rs1.
  - alu_b = in_b_sel_imm ? in_imm : resolved rs2.
- Hold refresh: while out_valid & ~out_ready & ~flush, if wb_fwd_valid and wb_fwd_rd matches the held non-zero rs1 (and A was not PC-selected), alu_a reloads wb_fwd_data. rs2/alu_b refresh the same way when not immediate-selected. EX forwarding is ignored during hold.
- Simultaneous drain and capture (out_valid & out_ready & in_valid): new entry loads, out_valid stays 1, no bubble.
- stall_count increments each cycle out_valid & ~out_ready and saturates at all-ones. It clears only on reset.

Decomposition:
- alu_control_t and encodings (ALU_ADD=4'b1000, ALU_SUB=4'b1100, ALU_SLT=4'b1101, ALU_SLTU=4'b1111) stay in alu_types.sv.
- Add a REG_ZERO constant to alu_types.sv.
- Sub-module operand_fwd_mux (param N, RA), instantiated for rs1 and rs2: inputs addr, rf data, ex/wb forwarding triple; output resolved data.

Test Plan:
- Reset mid-hold: entry held with out_ready=0, assert rst → out_valid=0, alu_a=0, alu_b=0, alu_control=0, stall_count=0 immediately, without waiting for a clock edge.
- Forwarding priority: rs1=5, ex_fwd(5,0xAAAA0000), wb_fwd(5,0x11111111), rf=0xDEADBEEF → alu_a=0xAAAA0000. Drop ex_fwd_valid → alu_a=0x11111111. Then rs1=0 with both forwarding to rd 0 → alu_a=0.
- Immediate/PC select: in_a_sel_pc=1, pc=0x100, in_b_sel_imm=1, imm=0xFFFFFFFC, control=ALU_ADD → alu_a=0x100, alu_b=0xFFFFFFFC, alu_control=4'b1000 after 1 cycle.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, stall_count=3. A wb_fwd matching held rs2=7 with data 0x42 → alu_b=0x42.
- Back-to-back throughput: out_ready=1, in_valid=1 for 8 cycles with distinct ops → 8 consecutive out_valid cycles, no bubbles, in order.
- Flush vs capture: flush=1 with in_valid=1 and in_ready=1 → next cycle out_valid=0, out_reg_write=0. Entry following flush deassertion captures normally.
